// File: rtl/tc_latch_pkg.sv
// Shared types and helpers for the latch-based register file.
package tc_latch_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Address width for a given word count; never narrower than one bit.
  function automatic int addr_width(input int num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

endpackage

// File: rtl/tc_latch_word.sv
// One storage word built from level-sensitive latches; no reset on the cells.
module tc_latch_word #(
  parameter int DataWidth = 32
) (
  input  logic                 gate_en,
  input  logic [DataWidth-1:0] wdata,
  output logic [DataWidth-1:0] word
);

  always_latch begin
    if (gate_en) word <= wdata;
  end

endmodule

// File: rtl/tc_latch_regfile.sv
// Latch-array register file: flop-staged write path, self-clearing after reset,
// combinational multi-port reads.
module tc_latch_regfile
  import tc_latch_pkg::*;
#(
  parameter  int NumWords     = 32,
  parameter  int DataWidth    = 32,
  parameter  int NumReadPorts = 2,
  localparam int AddrWidth    = addr_width(NumWords)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    we_i,
  input  logic [AddrWidth-1:0]                    waddr_i,
  input  logic [DataWidth-1:0]                    wdata_i,
  output logic                                    wready_o,
  input  logic [NumReadPorts-1:0][AddrWidth-1:0]  raddr_i,
  output logic [NumReadPorts-1:0][DataWidth-1:0]  rdata_o,
  output logic                                    init_busy_o
);

  function automatic logic [NumWords-1:0] decode(input logic [AddrWidth-1:0] addr);
    decode = '0;
    for (int w = 0; w < NumWords; w++) begin
      if (int'(addr) == w) decode[w] = 1'b1;
    end
  endfunction

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   clr_idx_p0;
  logic                   vld_p0;
  logic [DataWidth-1:0]   wdata_p0;
  logic [NumWords-1:0]    wsel_p0;

  logic                   wr_go;
  logic [AddrWidth-1:0]   wr_addr;
  logic [DataWidth-1:0]   wr_data;
  logic [NumWords-1:0]    latch_en;
  logic [DataWidth-1:0]   words [NumWords];

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_CLEAR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_CLEAR && int'(clr_idx_p0) == NumWords - 1) state_d = ST_IDLE;
  end

  always_comb begin
    wready_o    = (state_q == ST_IDLE);
    init_busy_o = (state_q == ST_CLEAR);
  end

  // The clear sequence borrows the normal write path, zeroing one word per cycle.
  always_comb begin
    wr_go   = we_i;
    wr_addr = waddr_i;
    wr_data = wdata_i;
    if (state_q == ST_CLEAR) begin
      wr_go   = 1'b1;
      wr_addr = clr_idx_p0;
      wr_data = '0;
    end
  end

  // Stage p0: registered write request feeding the latch array.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clr_idx_p0 <= '0;
      vld_p0     <= 1'b0;
      wdata_p0   <= '0;
      wsel_p0    <= '0;
    end else begin
      if (state_q == ST_CLEAR) begin
        clr_idx_p0 <= (state_d == ST_IDLE) ? '0 : clr_idx_p0 + AddrWidth'(1);
      end
      vld_p0   <= wr_go;
      wdata_p0 <= wr_data;
      wsel_p0  <= decode(wr_addr);
    end
  end

  // Gated enables: open only in the low phase after a write is staged.
  // Kept as one expression so a technology clock-gate cell can replace it.
  assign latch_en = {NumWords{~clk_i & vld_p0}} & wsel_p0;

  for (genvar w = 0; w < NumWords; w++) begin : g_word
    tc_latch_word #(
      .DataWidth(DataWidth)
    ) u_word (
      .gate_en(latch_en[w]),
      .wdata  (wdata_p0),
      .word   (words[w])
    );
  end

  always_comb begin
    for (int p = 0; p < NumReadPorts; p++) begin
      rdata_o[p] = '0;
      if (int'(raddr_i[p]) < NumWords) rdata_o[p] = words[raddr_i[p]];
    end
  end

endmodule

// File: tb/tb_tc_latch_regfile.sv
// Directed bench for tc_latch_regfile: a 32-word and a 24-word instance share stimulus.
module tb_tc_latch_regfile;

  logic             clk;
  logic             rst;
  logic             we;
  logic [4:0]       waddr;
  logic [31:0]      wdata;
  logic [1:0][4:0]  raddr;

  logic             wready32, busy32, wready24, busy24;
  logic [1:0][31:0] rd32, rd24;

  logic [31:0] exp32 [32];
  logic [31:0] exp24 [24];

  int checks = 0;
  int errors = 0;

  tc_latch_regfile u32 (
    .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .wready_o(wready32), .raddr_i(raddr), .rdata_o(rd32), .init_busy_o(busy32)
  );

  tc_latch_regfile #(.NumWords(24)) u24 (
    .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .wready_o(wready24), .raddr_i(raddr), .rdata_o(rd24), .init_busy_o(busy24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic zero_models();
    for (int i = 0; i < 32; i++) exp32[i] = '0;
    for (int i = 0; i < 24; i++) exp24[i] = '0;
  endtask

  task automatic write(input int a, input logic [31:0] d);
    we    = 1'b1;
    waddr = 5'(a);
    wdata = d;
    tick();
    we    = 1'b0;
    exp32[a] = d;
    if (a < 24) exp24[a] = d;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 32; a++) begin
      raddr[0] = 5'(a);
      raddr[1] = 5'(31 - a);
      #1;
      chk({tag, "_p0"}, rd32[0], exp32[a]);
      chk({tag, "_p1"}, rd32[1], exp32[31 - a]);
      chk({tag, "_24"}, rd24[0], (a < 24) ? exp24[a] : 32'h0);
    end
  endtask

  // Counts cycles with init_busy high after reset release; bounded.
  task automatic wait_clear(input string tag);
    int n32 = 0;
    int n24 = 0;
    while (busy32 === 1'b1 && n32 < 100) begin
      if (busy24 === 1'b1) n24++;
      tick();
      n32++;
    end
    chk({tag, "_len32"}, 32'(n32), 32'd32);
    chk({tag, "_len24"}, 32'(n24), 32'd24);
    chk({tag, "_wready"}, {31'b0, wready32}, 32'd1);
    chk({tag, "_wready24"}, {31'b0, wready24}, 32'd1);
    zero_models();
    tick();
  endtask

  initial begin
    rst   = 1'b1;
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    raddr = '0;
    zero_models();

    repeat (3) tick();
    chk("rst_busy", {31'b0, busy32}, 32'd1);
    chk("rst_wready", {31'b0, wready32}, 32'd0);
    chk("rst_busy24", {31'b0, busy24}, 32'd1);
    rst = 1'b0;
    wait_clear("clear");
    read_all("after_clear");

    write(5, 32'hDEADBEEF);
    raddr[0] = 5'd5;
    raddr[1] = 5'd4;
    tick();
    chk("single_w5", rd32[0], 32'hDEADBEEF);
    chk("single_w4", rd32[1], 32'h0);
    chk("single_w5_24", rd24[0], 32'hDEADBEEF);

    write(3, 32'h1);
    write(3, 32'h2);
    raddr[0] = 5'd3;
    #1;
    chk("b2b_mid_w3", rd32[0], 32'h1);
    write(7, 32'h3);
    tick();
    read_all("b2b");

    write(30, 32'h5A5A5A5A);
    raddr[0] = 5'd30;
    tick();
    chk("oor_read24", rd24[0], 32'h0);
    chk("oor_read32", rd32[0], 32'h5A5A5A5A);
    read_all("oor");

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("midclr_busy", {31'b0, busy32}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear("midclr");
    read_all("midclr");

    write(1, 32'hAB);
    raddr[0] = 5'd1;
    tick();
    chk("pre_rst_w1", rd32[0], 32'hAB);
    we    = 1'b1;
    waddr = 5'd1;
    wdata = 32'hFF;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    we  = 1'b0;
    chk("rstedge_busy", {31'b0, busy32}, 32'd1);
    wait_clear("rstedge");
    read_all("rstedge");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
